// File: rtl/fifo_sched_pkg.sv
// Shared types for the FIFO drain scheduler.
package fifo_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

endpackage

// File: rtl/fifo_sched_rr_pick.sv
// Combinational cyclic first-one search over a request vector, starting at ptr_i.
module fifo_sched_rr_pick #(
  parameter int unsigned NumFifos = 4,
  localparam int unsigned IdxWidth = (NumFifos > 1) ? $clog2(NumFifos) : 1
) (
  input  logic [NumFifos-1:0] req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic                valid_o,
  output logic [IdxWidth-1:0] idx_o
);

  localparam int unsigned SumWidth = IdxWidth + 1;

  logic [IdxWidth-1:0] w_cand [NumFifos];
  logic [NumFifos-1:0] w_rot;

  // w_cand[gi] is the FIFO index gi steps after the pointer, wrapped at NumFifos
  for (genvar gi = 0; gi < NumFifos; gi++) begin : g_cand
    logic [SumWidth-1:0] w_sum;
    assign w_sum       = {1'b0, ptr_i} + SumWidth'(gi);
    assign w_cand[gi]  = (w_sum >= SumWidth'(NumFifos)) ?
                         IdxWidth'(w_sum - SumWidth'(NumFifos)) : IdxWidth'(w_sum);
    assign w_rot[gi]   = req_i[w_cand[gi]];
  end

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NumFifos - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        valid_o = 1'b1;
        idx_o   = w_cand[i];
      end
    end
  end

endmodule

// File: rtl/fifo_drain_sched.sv
// Round-robin burst drain scheduler: grants one FIFO at a time for up to MaxBurst
// beats and forwards its head entry as a valid/ready stream tagged with its index.
module fifo_drain_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NumFifos   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MaxBurst   = 4,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  localparam int unsigned IdxWidth  = (NumFifos > 1) ? $clog2(NumFifos) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [NumFifos-1:0] fifo_empty_i,
  input  dtype                fifo_data_i [NumFifos],
  output logic [NumFifos-1:0] fifo_pop_o,
  output logic                valid_o,
  input  logic                ready_i,
  output dtype                data_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                last_o
);

  localparam int unsigned CntWidth = $clog2(MaxBurst + 1);

  sched_state_e        r_state;
  logic [IdxWidth-1:0] r_idx;
  logic [IdxWidth-1:0] r_rr_ptr;
  logic [CntWidth-1:0] r_cnt;

  logic                w_pick_valid;
  logic [IdxWidth-1:0] w_pick_idx;
  logic                w_valid;
  logic                w_last;
  logic                w_handshake;
  logic                w_src_empty;
  logic [IdxWidth-1:0] w_next_ptr;

  fifo_sched_rr_pick #(
    .NumFifos (NumFifos)
  ) u_rr_pick (
    .req_i   (~fifo_empty_i),
    .ptr_i   (r_rr_ptr),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  assign w_src_empty = fifo_empty_i[r_idx];
  assign w_valid     = (r_state == BURST) & ~w_src_empty;
  assign w_last      = w_valid & (r_cnt == CntWidth'(MaxBurst - 1));
  assign w_handshake = w_valid & ready_i;
  assign w_next_ptr  = (r_idx == IdxWidth'(NumFifos - 1)) ? '0 : r_idx + IdxWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_idx   <= w_pick_idx;
            r_cnt   <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          // An empty source ends the grant early so other queues are not stalled
          if (w_src_empty) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
            r_cnt    <= '0;
          end else if (w_handshake) begin
            if (w_last) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + CntWidth'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NumFifos; gi++) begin : g_pop
    assign fifo_pop_o[gi] = w_handshake & ~flush_i & (r_idx == IdxWidth'(gi));
  end

  assign valid_o = w_valid;
  assign last_o  = w_last;
  assign idx_o   = r_idx;
  assign data_o  = fifo_data_i[r_idx];

`ifndef SYNTHESIS
  if (NumFifos < 1) begin : g_bad_num_fifos
    $error("fifo_drain_sched: NumFifos must be at least 1");
  end
  if (MaxBurst < 1) begin : g_bad_max_burst
    $error("fifo_drain_sched: MaxBurst must be at least 1");
  end

  a_pop_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(fifo_pop_o));

  a_pop_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fifo_pop_o & fifo_empty_i) == '0);
`endif

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Bench for fifo_drain_sched: FIFO bank model, per-cycle table plus scoreboarded bursts.
module tb_fifo_drain_sched;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic rdy;
    logic exp_valid;
    logic exp_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ready;

  logic [3:0]  empty4;
  logic [31:0] data4 [4];
  logic [3:0]  pop4;
  logic        valid4;
  logic [31:0] dout4;
  logic [1:0]  idx4;
  logic        last4;

  logic [2:0]  empty3;
  logic [31:0] data3 [3];
  logic [2:0]  pop3;
  logic        valid3;
  logic [31:0] dout3;
  logic [1:0]  idx3;
  logic        last3;

  logic [31:0] m4 [4][32];
  int          h4 [4];
  int          t4 [4];
  logic [31:0] m3 [3][32];
  int          h3 [3];
  int          t3 [3];

  beat_t       exp4[$];
  beat_t       exp3[$];
  int          hs_cyc[$];
  int          cyc_n = 0;
  logic [7:0]  tid = 8'h00;

  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fifo_drain_sched #(.NumFifos(4), .DATA_WIDTH(32), .MaxBurst(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fifo_empty_i(empty4), .fifo_data_i(data4), .fifo_pop_o(pop4),
    .valid_o(valid4), .ready_i(ready), .data_o(dout4), .idx_o(idx4), .last_o(last4)
  );

  fifo_drain_sched #(.NumFifos(3), .DATA_WIDTH(32), .MaxBurst(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fifo_empty_i(empty3), .fifo_data_i(data3), .fifo_pop_o(pop3),
    .valid_o(valid3), .ready_i(ready), .data_o(dout3), .idx_o(idx3), .last_o(last3)
  );

  function automatic logic [31:0] val(int f, int k);
    logic [7:0] fb;
    fb = 8'hA0 + 8'(f);
    return {fb, tid, k[15:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 4; i++) begin h4[i] = 0; t4[i] = 0; end
    for (int i = 0; i < 3; i++) begin h3[i] = 0; t3[i] = 0; end
  endtask

  task automatic load4(int f, int n);
    for (int j = 0; j < n; j++) begin
      m4[f][t4[f]] = val(f, t4[f]);
      t4[f]++;
    end
  endtask

  task automatic load3(int f, int n);
    for (int j = 0; j < n; j++) begin
      m3[f][t3[f]] = val(f, t3[f]);
      t3[f]++;
    end
  endtask

  task automatic push4(int f, int k, logic last);
    beat_t b;
    b.idx = 2'(f); b.data = val(f, k); b.last = last;
    exp4.push_back(b);
  endtask

  task automatic push3(int f, int k, logic last);
    beat_t b;
    b.idx = 2'(f); b.data = val(f, k); b.last = last;
    exp3.push_back(b);
  endtask

  // Present the model FIFO heads to the DUTs and let the combinational outputs settle
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      empty4[i] = (h4[i] == t4[i]);
      data4[i]  = m4[i][h4[i]];
    end
    for (int i = 0; i < 3; i++) begin
      empty3[i] = (h3[i] == t3[i]);
      data3[i]  = m3[i][h3[i]];
    end
    #1;
  endtask

  task automatic advance();
    beat_t      e;
    logic [3:0] ep4;
    logic [2:0] ep3;
    logic [3:0] p4;
    logic [2:0] p3;
    logic       fl;
    fl  = flush;
    ep4 = '0;
    ep3 = '0;
    if (valid4 && ready && !flush) begin
      hs_cyc.push_back(cyc_n);
      if (exp4.size() == 0) begin
        chk("sb4_unexpected_beat", {30'd0, idx4}, 32'hFFFF_FFFF);
      end else begin
        e = exp4.pop_front();
        chk("idx4", {30'd0, idx4}, {30'd0, e.idx});
        chk("data4", dout4, e.data);
        chk("last4", {31'd0, last4}, {31'd0, e.last});
        ep4 = 4'b0001 << e.idx;
      end
    end
    if (!valid4) chk("last4_without_valid", {31'd0, last4}, 32'd0);
    chk("pop4", {28'd0, pop4}, {28'd0, ep4});
    if (valid3 && ready && !flush) begin
      if (exp3.size() == 0) begin
        chk("sb3_unexpected_beat", {30'd0, idx3}, 32'hFFFF_FFFF);
      end else begin
        e = exp3.pop_front();
        chk("idx3", {30'd0, idx3}, {30'd0, e.idx});
        chk("data3", dout3, e.data);
        chk("last3", {31'd0, last3}, {31'd0, e.last});
        ep3 = 3'b001 << e.idx;
      end
    end
    chk("pop3", {29'd0, pop3}, {29'd0, ep3});
    p4 = pop4;
    p3 = pop3;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < 4; i++) if (p4[i] && h4[i] < t4[i]) h4[i]++;
    for (int i = 0; i < 3; i++) if (p3[i] && h3[i] < t3[i]) h3[i]++;
    if (fl) clear_models();
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic drain(int max);
    int c;
    c = 0;
    while ((exp4.size() != 0 || exp3.size() != 0) && c < max) begin
      cyc();
      c++;
    end
    chk("beats_outstanding", exp4.size() + exp3.size(), 0);
  endtask

  task automatic do_reset(logic clr);
    tid   = tid + 8'h01;
    rst_n = 1'b0;
    if (clr) begin
      clear_models();
      exp4.delete();
      exp3.delete();
    end
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl [15];
    logic [14:0] v_pat;
    logic [14:0] l_pat;

    rst_n = 1'b0;
    flush = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 32; j++) m4[i][j] = '0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 32; j++) m3[i][j] = '0;
    clear_models();

    // Reset state with a loaded FIFO present: nothing may be popped or presented
    load4(1, 2);
    repeat (2) begin
      settle();
      chk("rst_valid", {31'd0, valid4}, 32'd0);
      chk("rst_last", {31'd0, last4}, 32'd0);
      chk("rst_idx", {30'd0, idx4}, 32'd0);
      chk("rst_valid3", {31'd0, valid3}, 32'd0);
      advance();
    end

    // Single busy FIFO, 10 entries: bursts of 4,4,2 with bubbles, per-cycle table
    do_reset(1'b1);
    v_pat = 15'b001101111011110;
    l_pat = 15'b000001000010000;
    for (int i = 0; i < 15; i++) begin
      tbl[i].rdy       = 1'b1;
      tbl[i].exp_valid = v_pat[i];
      tbl[i].exp_last  = l_pat[i];
    end
    load4(2, 10);
    for (int k = 0; k < 10; k++) push4(2, k, (k == 3) || (k == 7));
    for (int i = 0; i < 15; i++) begin
      ready = tbl[i].rdy;
      settle();
      chk("tbl_valid", {31'd0, valid4}, {31'd0, tbl[i].exp_valid});
      chk("tbl_last", {31'd0, last4}, {31'd0, tbl[i].exp_last});
      if (tbl[i].exp_valid) chk("tbl_idx", {30'd0, idx4}, 32'd2);
      advance();
    end
    drain(5);

    // Two loaded FIFOs alternate 0,3,0,3 with a bubble between grants
    do_reset(1'b1);
    hs_cyc.delete();
    load4(0, 8);
    load4(3, 8);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (b % 2 == 0) push4(0, (b / 2) * 4 + k, k == 3);
        else            push4(3, (b / 2) * 4 + k, k == 3);
      end
    end
    drain(40);
    chk("rr_beat_count", hs_cyc.size(), 16);
    if (hs_cyc.size() == 16)
      for (int b = 1; b < 4; b++) chk("rr_grant_spacing", hs_cyc[4 * b] - hs_cyc[4 * b - 4], 5);

    // Back-pressure holds the presented beat and the burst count
    do_reset(1'b1);
    load4(1, 4);
    for (int k = 0; k < 4; k++) push4(1, k, k == 3);
    cyc();
    cyc();
    ready = 1'b0;
    repeat (3) begin
      settle();
      chk("hold_valid", {31'd0, valid4}, 32'd1);
      chk("hold_data", dout4, val(1, 1));
      chk("hold_idx", {30'd0, idx4}, 32'd1);
      advance();
    end
    ready = 1'b1;
    drain(10);

    // Three-FIFO pointer wrap: after FIFO 2 releases, FIFO 0 wins over FIFO 2
    do_reset(1'b1);
    load3(2, 2);
    push3(2, 0, 1'b0);
    push3(2, 1, 1'b0);
    drain(10);
    cyc();
    cyc();
    load3(0, 2);
    load3(2, 2);
    push3(0, 0, 1'b0);
    push3(0, 1, 1'b0);
    push3(2, 2, 1'b0);
    push3(2, 3, 1'b0);
    drain(20);

    // Flush during the second beat: no pop, then idle with the pointer back at 0
    do_reset(1'b1);
    load4(1, 6);
    push4(1, 0, 1'b0);
    cyc();
    cyc();
    flush = 1'b1;
    settle();
    chk("flush_beat_valid", {31'd0, valid4}, 32'd1);
    advance();
    flush = 1'b0;
    load4(3, 1);
    load4(0, 1);
    push4(0, 0, 1'b0);
    push4(3, 0, 1'b0);
    settle();
    chk("flush_idle_valid", {31'd0, valid4}, 32'd0);
    advance();
    drain(20);

    // Reset mid-burst: outputs at reset values, arbitration restarts from FIFO 0
    do_reset(1'b1);
    load4(2, 6);
    push4(2, 0, 1'b0);
    push4(2, 1, 1'b0);
    cyc();
    cyc();
    cyc();
    rst_n = 1'b0;
    load4(0, 2);
    repeat (2) begin
      settle();
      chk("midrst_valid", {31'd0, valid4}, 32'd0);
      chk("midrst_last", {31'd0, last4}, 32'd0);
      chk("midrst_idx", {30'd0, idx4}, 32'd0);
      advance();
    end
    rst_n = 1'b1;
    push4(0, 0, 1'b0);
    push4(0, 1, 1'b0);
    for (int k = 2; k < 6; k++) push4(2, k, k == 5);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
